bp_table_ctrl: RTL
==================

// Module: bp_table_ctrl
// PURPOSE
//  Sequencer/arbiter for the branch-predictor counter SRAM (3b entries {valid, 2b sat ctr}, write port 0, read port 1).
//  Owns write port 0: after reset (and on clear_req) it sweeps every entry invalid.
//  Otherwise it drains a FIFO of backend branch resolutions, one saturating read-modify-write per cycle.
//  Owns read port 1 for fetch; forms guess_jmp/guess_2bsat, with write->read forwarding on same-index collisions.
// PARAMETERS
//  SET_IDX  8  index bits; table has 2**SET_IDX entries; index = pc[SET_IDX+1:2]
//  DEPTH    4  update FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  clear_req    in   1        pulse: flush FIFO, re-run invalidate sweep
//  upd_valid    in   1        backend resolved conditional branch
//  upd_ready    out  1        FIFO can accept (= state==RUN && !full)
//  upd_pc       in   32       resolved branch pc
//  upd_taken    in   1        actual direction
//  upd_2bsat    in   2        counter value used at prediction time
//  fetch_pc     in   32       fetch pc, read every cycle
//  guess_jmp    out  1        prediction for fetch_pc of previous cycle
//  guess_2bsat  out  2        counter for fetch_pc of previous cycle
//  init_busy    out  1        invalidate sweep in progress
//  sram_csb0    out  1        write-port chip select, active low
//  sram_addr0   out  SET_IDX  write index
//  sram_din0    out  3        write data {valid, ctr}
//  sram_csb1    out  1        read-port chip select, active low; tied 0
//  sram_addr1   out  SET_IDX  = fetch_pc[SET_IDX+1:2]
//  sram_dout1   in   3        read data, valid the cycle after addr1
// BEHAVIOUR
//  Reset (async): state=INIT, sweep_idx=0, FIFO empty, rd/wr ptrs=0, fwd_hit=0.
//   Outputs during reset: upd_ready=0, init_busy=1, sram_csb0=1, guess_2bsat=2'b10, guess_jmp=1.
//  FSM INIT: each cycle csb0=0, addr0=sweep_idx, din0=3'b000, sweep_idx++.
//   After writing index 2**SET_IDX-1 -> RUN; the sweep is exactly 2**SET_IDX cycles.
//   upd_ready=0 and init_busy=1 throughout; clear_req is ignored.
//  FSM RUN: upd_ready=!full. Push on upd_valid&&upd_ready; store {pc index, taken, 2bsat}.
//   FIFO non-empty: pop head the same cycle and drive csb0=0, addr0=head.idx, din0={1, new_ctr}.
//   new_ctr: taken ? min(2bsat+1, 3) : max(2bsat-1, 0). Saturating, 2-bit, no wrap.
//   FIFO empty: csb0=1. Push to empty FIFO at edge N -> SRAM written at edge N+1.
//   Push and pop in the same cycle are legal at any occupancy < full; count is unchanged.
//   Pointers wrap modulo DEPTH. full when count==DEPTH; push while full is impossible (ready=0).
//   clear_req in RUN: FIFO emptied at next edge (entries discarded, no write), sweep_idx=0, -> INIT.
//   A pop coinciding with clear_req still writes that cycle.
//  Guess path (1-cycle latency): register rd_idx=addr1 and fwd = (csb0==0 && addr0==addr1), fwd_data=din0.
//   Next cycle: e = fwd ? fwd_data : sram_dout1.
//   guess_2bsat = (state==INIT || !e[2]) ? 2'b10 : e[1:0]; guess_jmp = guess_2bsat[1].
//   Forwarding also applies to sweep writes, so an invalidated entry yields 2'b10.
//  No combinational path from upd_valid to upd_ready.
//  Reset asserted mid-sweep or mid-drain: all state lost immediately, sweep restarts after release.
// TESTING (SET_IDX=4, DEPTH=4)
//  Reset release -> init_busy high 16 cycles, addr0 0..15, din0=000; upd_ready rises cycle 17; guess=2'b10 throughout.
//  Push pc=0x20,taken=1,2bsat=11 -> write idx 8 din0=3'b111; then fetch_pc=0x20 -> guess_2bsat=11, guess_jmp=1.
//  Push pc=0x24,taken=0,2bsat=00 -> din0=3'b100; then 2bsat=10 -> din0=3'b101 (saturate and decrement).
//  Hold csb0 busy: 5 back-to-back pushes with no stalls -> 1 write/cycle, 5 writes in push order, ready stays 1.
//  fetch_pc=0x20 in the same cycle as a write to idx 8 of din0=3'b100 -> next-cycle guess_2bsat=00 (forwarded, not dout1).
//  clear_req with 3 entries queued -> at most 1 write, others dropped, 16-cycle sweep, all guesses 2'b10 afterwards.
//  rst_n low at sweep_idx=7 -> outputs at reset values at once; a full 16-cycle sweep follows release.

Source files
------------

// File: rtl/bp_table_ctrl_if.sv
// Branch-resolution update handshake between the backend (master) and the
// predictor table controller (slave).
interface bp_table_ctrl_if;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [1:0]  upd_2bsat;

    modport master (output upd_valid, output upd_pc, output upd_taken, output upd_2bsat,
                    input  upd_ready);
    modport slave  (input  upd_valid, input  upd_pc, input  upd_taken, input  upd_2bsat,
                    output upd_ready);
endinterface

// File: rtl/bp_table_ctrl.sv
// Branch-predictor counter SRAM sequencer: invalidate sweep, update FIFO drain
// (one saturating RMW per cycle) and fetch-side guess with write forwarding.
module bp_table_ctrl #(
    parameter int SET_IDX = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear_req,
    bp_table_ctrl_if.slave     upd,
    input  logic [31:0]        fetch_pc,
    output logic               guess_jmp,
    output logic [1:0]         guess_2bsat,
    output logic               init_busy,
    output logic               sram_csb0,
    output logic [SET_IDX-1:0] sram_addr0,
    output logic [2:0]         sram_din0,
    output logic               sram_csb1,
    output logic [SET_IDX-1:0] sram_addr1,
    input  logic [2:0]         sram_dout1
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = SET_IDX + 3;

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t               state_r, state_nx_s;
    logic [SET_IDX-1:0]   sweep_idx_r;
    logic [EW-1:0]        fifo_mem_r [DEPTH];
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [PW:0]          count_r;
    logic                 fwd_hit_r;
    logic [2:0]           fwd_data_r;

    logic                 full_s, empty_s, push_s, pop_s, clear_s;
    logic [EW-1:0]        head_s;
    logic                 csb0_s, ready_s, busy_s;
    logic [SET_IDX-1:0]   addr0_s;
    logic [2:0]           din0_s, entry_s;
    logic                 unused_bits_s;

    function automatic logic [1:0] sat_next(input logic taken, input logic [1:0] ctr);
        logic [1:0] r;
        if (taken) r = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        else       r = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        return r;
    endfunction

    assign full_s  = (count_r == (PW+1)'(DEPTH));
    assign empty_s = (count_r == {(PW+1){1'b0}});
    assign head_s  = fifo_mem_r[rd_ptr_r];
    assign push_s  = (state_r == ST_RUN) && upd.upd_valid && ready_s;
    assign pop_s   = (state_r == ST_RUN) && !empty_s;
    assign clear_s = (state_r == ST_RUN) && clear_req;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_INIT;
        else        state_r <= state_nx_s;
    end

    // Next-state logic: sweep ends after the last index, clear restarts it
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_INIT: if (sweep_idx_r == {SET_IDX{1'b1}}) state_nx_s = ST_RUN;
                     else                                 state_nx_s = ST_INIT;
            ST_RUN:  if (clear_req) state_nx_s = ST_INIT;
                     else           state_nx_s = ST_RUN;
            default: state_nx_s = ST_INIT;
        endcase
    end

    // Output logic: write-port ownership and handshake
    always_comb begin
        csb0_s  = 1'b1;
        addr0_s = {SET_IDX{1'b0}};
        din0_s  = 3'b000;
        ready_s = 1'b0;
        busy_s  = 1'b0;
        case (state_r)
            ST_INIT: begin
                csb0_s  = 1'b0;
                addr0_s = sweep_idx_r;
                busy_s  = 1'b1;
            end
            ST_RUN: begin
                ready_s = !full_s;
                if (!empty_s) begin
                    csb0_s  = 1'b0;
                    addr0_s = head_s[EW-1:3];
                    din0_s  = {1'b1, sat_next(head_s[2], head_s[1:0])};
                end else begin
                    csb0_s  = 1'b1;
                end
            end
            default: begin
                csb0_s = 1'b1;
                busy_s = 1'b1;
            end
        endcase
    end

    // Sweep index: counts through the table in INIT, rearmed by clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  sweep_idx_r <= {SET_IDX{1'b0}};
        else if (state_r == ST_INIT) sweep_idx_r <= sweep_idx_r + SET_IDX'(1);
        else if (clear_s)            sweep_idx_r <= {SET_IDX{1'b0}};
        else                         sweep_idx_r <= sweep_idx_r;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else if (clear_s) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: {index, taken, counter at prediction}
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= {upd.upd_pc[SET_IDX+1:2], upd.upd_taken, upd.upd_2bsat};
    end

    // Forwarding capture: a same-cycle write to the fetched index overrides dout1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hit_r  <= 1'b0;
            fwd_data_r <= 3'b000;
        end else begin
            fwd_hit_r  <= !sram_csb0 && (sram_addr0 == sram_addr1);
            fwd_data_r <= sram_din0;
        end
    end

    assign entry_s       = fwd_hit_r ? fwd_data_r : sram_dout1;
    assign guess_2bsat   = ((state_r == ST_INIT) || !entry_s[2]) ? 2'b10 : entry_s[1:0];
    assign guess_jmp     = guess_2bsat[1];
    assign init_busy     = busy_s;
    assign upd.upd_ready = ready_s;
    // Write port stays deselected while reset is held, even though state is INIT
    assign sram_csb0     = csb0_s | ~rst_n;
    assign sram_addr0    = addr0_s;
    assign sram_din0     = din0_s;
    assign sram_csb1     = 1'b0;
    assign sram_addr1    = fetch_pc[SET_IDX+1:2];
    assign unused_bits_s = ^{fetch_pc[31:SET_IDX+2], fetch_pc[1:0],
                             upd.upd_pc[31:SET_IDX+2], upd.upd_pc[1:0]};
endmodule
